// File: rtl/stdcore_pkg.sv
// Shared constants and helpers for the stdcore FIFO/RF slice.
package stdcore_pkg;

    localparam int OUT_DEPTH = 2;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((32'sd1 <<< r) < n) begin
            r = r + 32'sd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/stdcore_2prf.sv
// Two-port register file: one write port, one read port with a registered read result.
module stdcore_2prf
#(
    parameter int DW    = 8,
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic          wclk,
    input  logic          we_n,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          rclk,
    input  logic          re_n,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rd_word_d;
    logic [DW-1:0] rdata_q;

    // Word write, decoded per entry so DEPTH need not be a power of two.
    always_ff @(posedge wclk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!we_n && (waddr == AW'(i))) begin
                mem_q[i] <= wdata;
            end
        end
    end

    // Read mux ahead of the output register.
    always_comb begin
        rd_word_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rd_word_d = (raddr == AW'(i)) ? mem_q[i] : rd_word_d;
        end
    end

    // Registered read: data appears the cycle after re_n is sampled low.
    always_ff @(posedge rclk) begin
        if (!re_n) begin
            rdata_q <= rd_word_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/stdcore_2prf_fifo_chk.sv
// Invariant checker for the 2PRF FIFO control state; carries no functional logic.
module stdcore_2prf_fifo_chk
    import stdcore_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int AW    = 9,
    parameter int MCW   = 10,
    parameter int OCW   = 2
) (
    input logic           clk,
    input logic           rst_n,
    input logic [MCW-1:0] mem_cnt,
    input logic [OCW-1:0] out_cnt,
    input logic           pop,
    input logic           we_n,
    input logic           re_n,
    input logic [AW-1:0]  waddr,
    input logic [AW-1:0]  raddr
);

    a_out_cnt_max: assert property (@(posedge clk) disable iff (!rst_n)
        out_cnt <= OCW'(OUT_DEPTH));

    a_mem_cnt_max: assert property (@(posedge clk) disable iff (!rst_n)
        mem_cnt <= MCW'(DEPTH));

    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
        pop |-> (out_cnt != '0));

    a_no_write_full: assert property (@(posedge clk) disable iff (!rst_n)
        !we_n |-> (mem_cnt < MCW'(DEPTH)));

    a_no_rw_conflict: assert property (@(posedge clk) disable iff (!rst_n)
        !(!we_n && !re_n && (waddr == raddr)));

endmodule

// File: rtl/stdcore_2prf_fifo.sv
// Valid/ready FIFO on a 2-port RF; a 2-entry prefetch stage hides the RF read latency
// so rd_data comes straight from a flop and pops can run every cycle.
module stdcore_2prf_fifo
    import stdcore_pkg::*;
#(
    parameter int DW       = 8,
    parameter int DEPTH    = 512,
    parameter int AW       = 9,
    parameter int AFULL_TH = DEPTH - 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic [AW+1:0] count,
    output logic          almost_full
);

    localparam int MCW   = clog2(DEPTH + 1);
    localparam int OCW   = clog2(OUT_DEPTH + 1);
    localparam int CNT_W = clog2(DEPTH + OUT_DEPTH + 1);
    localparam int AF_TH = (AFULL_TH < 0) ? 0 : AFULL_TH;

    logic           rst_n_q;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [MCW-1:0] mem_cnt_q, mem_cnt_d;
    logic           inflight_q, inflight_d;
    logic [OCW-1:0] out_cnt_q, out_cnt_d;
    logic [DW-1:0]  q0_q, q0_d;
    logic [DW-1:0]  q1_q, q1_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic           almost_full_q, almost_full_d;

    logic           wr_ready_s;
    logic           push_s;
    logic           pop_s;
    logic           issue_s;
    logic [OCW:0]   avail_s;
    logic [OCW-1:0] slot_s;
    logic           we_n_s;
    logic           re_n_s;
    logic [DW-1:0]  rf_rdata_s;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        if (p == AW'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + AW'(1);
        end
    endfunction

    // Handshakes, read-issue decision and pointer/occupancy next state.
    always_comb begin
        wr_ready_s = rst_n_q && (mem_cnt_q < MCW'(DEPTH));
        push_s     = wr_valid && wr_ready_s;
        pop_s      = (out_cnt_q != '0) && rd_ready;
        // Words that will sit in the prefetch stage once this cycle's pop and landing read settle.
        avail_s    = {1'b0, out_cnt_q} + (OCW+1)'(inflight_q) - (OCW+1)'(pop_s);
        issue_s    = (mem_cnt_q != '0) && (avail_s < (OCW+1)'(OUT_DEPTH));
        we_n_s     = ~push_s;
        re_n_s     = ~issue_s;
        wr_ptr_d   = push_s  ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = issue_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        mem_cnt_d  = mem_cnt_q + MCW'(push_s) - MCW'(issue_s);
        inflight_d = issue_s;
    end

    // Prefetch stage: shift on pop, then land the RF result in the first free slot.
    always_comb begin
        slot_s    = out_cnt_q - OCW'(pop_s);
        out_cnt_d = slot_s + OCW'(inflight_q);
        q1_d      = q1_q;
        if (pop_s) begin
            q0_d = q1_q;
        end else begin
            q0_d = q0_q;
        end
        if (inflight_q) begin
            if (slot_s == '0) begin
                q0_d = rf_rdata_s;
            end else begin
                q1_d = rf_rdata_s;
            end
        end else begin
            q1_d = q1_q;
        end
        count_d       = CNT_W'(mem_cnt_d) + CNT_W'(inflight_d) + CNT_W'(out_cnt_d);
        almost_full_d = (int'(count_d) >= AF_TH);
    end

    // State registers with synchronous active-low reset; RF contents are left alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rst_n_q       <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            mem_cnt_q     <= '0;
            inflight_q    <= 1'b0;
            out_cnt_q     <= '0;
            q0_q          <= '0;
            q1_q          <= '0;
            count_q       <= '0;
            almost_full_q <= 1'b0;
        end else begin
            rst_n_q       <= 1'b1;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            mem_cnt_q     <= mem_cnt_d;
            inflight_q    <= inflight_d;
            out_cnt_q     <= out_cnt_d;
            q0_q          <= q0_d;
            q1_q          <= q1_d;
            count_q       <= count_d;
            almost_full_q <= almost_full_d;
        end
    end

    stdcore_2prf #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .wclk  (clk),
        .we_n  (we_n_s),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .rclk  (clk),
        .re_n  (re_n_s),
        .raddr (rd_ptr_q),
        .rdata (rf_rdata_s)
    );

    stdcore_2prf_fifo_chk #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .MCW   (MCW),
        .OCW   (OCW)
    ) u_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .mem_cnt (mem_cnt_q),
        .out_cnt (out_cnt_q),
        .pop     (pop_s),
        .we_n    (we_n_s),
        .re_n    (re_n_s),
        .waddr   (wr_ptr_q),
        .raddr   (rd_ptr_q)
    );

    assign wr_ready    = wr_ready_s;
    assign rd_valid    = (out_cnt_q != '0);
    assign rd_data     = q0_q;
    assign count       = (AW+2)'(count_q);
    assign almost_full = almost_full_q;

endmodule

// File: tb/tb_stdcore_2prf_fifo.sv
// Directed-vector and scoreboard bench for stdcore_2prf_fifo with DEPTH=5.
module tb_stdcore_2prf_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 5;
    localparam int AW    = 3;
    localparam int AFTH  = 6;

    logic          clk;
    logic          rst_n;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic [AW+1:0] count;
    logic          almost_full;

    typedef struct {
        logic       rst_n;
        logic       wv;
        logic [7:0] wd;
        logic       rr;
        logic       e_wr;
        logic       e_rv;
        logic       chk_d;
        logic [7:0] e_d;
        int         e_cnt;
        logic       e_af;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] sb[$];
    int         n_checks;
    int         n_fail;

    stdcore_2prf_fifo #(
        .DW       (DW),
        .DEPTH    (DEPTH),
        .AW       (AW),
        .AFULL_TH (AFTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .count       (count),
        .almost_full (almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks = n_checks + 1;
        if (act != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 'h%0h required 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic wv, input logic [7:0] wd, input logic rr,
                       input logic ewr, input logic erv, input logic cd, input logic [7:0] ed,
                       input int ec, input logic eaf);
        vec_t v;
        v.rst_n = r;   v.wv = wv;    v.wd = wd;    v.rr = rr;
        v.e_wr  = ewr; v.e_rv = erv; v.chk_d = cd; v.e_d = ed;
        v.e_cnt = ec;  v.e_af = eaf;
        vecs.push_back(v);
    endtask

    // One cycle against the scoreboard: drive at a falling edge, judge after the next one.
    task automatic drive_cycle(input logic wv, input logic [7:0] wd, input logic rr,
                               output logic pushed, output logic popped);
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        pushed   = wv && wr_ready;
        popped   = rr && rd_valid;
        if (popped) begin
            if (sb.size() == 0) begin
                check("pop_from_empty", 1, 0);
            end else begin
                check("rd_data_order", int'(rd_data), int'(sb.pop_front()));
            end
        end
        if (pushed) begin
            sb.push_back(wd);
        end
        @(negedge clk);
        check("count_model", int'(count), sb.size());
        check("afull_model", int'(almost_full), int'(sb.size() >= AFTH));
        check("wr_ready_low_not_full", int'(!wr_ready && (sb.size() < DEPTH)), 0);
        check("rd_valid_when_empty", int'(rd_valid && (sb.size() == 0)), 0);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic pu;
        logic po;
        int   sent;
        int   got;
        int   pushed_n;
        int   cyc;
        int   wp;
        int   rp;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        rd_ready = 1'b0;

        // rst wv wd rr | wr_ready rd_valid chk_d rd_data count afull
        // Reset then idle.
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0);
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0);
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0);
        // Single word: visible two edges after the push, gone after one pop.
        add(1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1, 1'b0);
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1, 1'b0);
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA5, 1, 1'b0);
        add(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0);
        // Fill with rd_ready low: 5 in the RF plus 2 prefetched.
        add(1'b1, 1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1, 1'b0);
        add(1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2, 1'b0);
        add(1'b1, 1'b1, 8'h12, 1'b0, 1'b1, 1'b1, 1'b1, 8'h10, 3, 1'b0);
        add(1'b1, 1'b1, 8'h13, 1'b0, 1'b1, 1'b1, 1'b1, 8'h10, 4, 1'b0);
        add(1'b1, 1'b1, 8'h14, 1'b0, 1'b1, 1'b1, 1'b1, 8'h10, 5, 1'b0);
        add(1'b1, 1'b1, 8'h15, 1'b0, 1'b1, 1'b1, 1'b1, 8'h10, 6, 1'b1);
        add(1'b1, 1'b1, 8'h16, 1'b0, 1'b0, 1'b1, 1'b1, 8'h10, 7, 1'b1);
        add(1'b1, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b1, 1'b1, 8'h10, 7, 1'b1);
        // Pop while full with a push offered: the push is refused, wr_ready returns after.
        add(1'b1, 1'b1, 8'hEE, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 6, 1'b1);
        add(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h12, 5, 1'b0);
        add(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h13, 4, 1'b0);
        add(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h14, 3, 1'b0);
        add(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h15, 2, 1'b0);
        add(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h16, 1, 1'b0);
        add(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0);
        // Mid-stream reset with 3 words held, then a fresh word.
        add(1'b1, 1'b1, 8'h30, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1, 1'b0);
        add(1'b1, 1'b1, 8'h31, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2, 1'b0);
        add(1'b1, 1'b1, 8'h32, 1'b0, 1'b1, 1'b1, 1'b1, 8'h30, 3, 1'b0);
        add(1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0);
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0);
        add(1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1, 1'b0);
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1, 1'b0);
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h3C, 1, 1'b0);
        add(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n    = vecs[i].rst_n;
            wr_valid = vecs[i].wv;
            wr_data  = vecs[i].wd;
            rd_ready = vecs[i].rr;
            @(negedge clk);
            check($sformatf("v%0d_wr_ready", i), int'(wr_ready), int'(vecs[i].e_wr));
            check($sformatf("v%0d_rd_valid", i), int'(rd_valid), int'(vecs[i].e_rv));
            check($sformatf("v%0d_count", i), int'(count), vecs[i].e_cnt);
            check($sformatf("v%0d_almost_full", i), int'(almost_full), int'(vecs[i].e_af));
            if (vecs[i].chk_d) begin
                check($sformatf("v%0d_rd_data", i), int'(rd_data), int'(vecs[i].e_d));
            end
        end

        // Streaming 0..19 with both sides held active: in order, no bubble after the first word.
        sent = 0;
        got  = 0;
        cyc  = 0;
        while ((got < 20) && (cyc < 200)) begin
            drive_cycle(sent < 20, 8'(sent), 1'b1, pu, po);
            if ((got > 0) && (got < 20)) begin
                check("stream_no_gap", int'(po), 1);
            end
            if (pu) sent = sent + 1;
            if (po) got = got + 1;
            cyc = cyc + 1;
        end
        check("stream_words_received", got, 20);

        // Random traffic at 30/50/90 percent on each side against the scoreboard.
        pushed_n = 0;
        cyc      = 0;
        while (((pushed_n < 10000) || (sb.size() != 0)) && (cyc < 80000)) begin
            case ((cyc / 256) % 3)
                0:       wp = 30;
                1:       wp = 50;
                default: wp = 90;
            endcase
            case ((cyc / 768) % 3)
                0:       rp = 30;
                1:       rp = 50;
                default: rp = 90;
            endcase
            drive_cycle((pushed_n < 10000) && ($urandom_range(0, 99) < wp),
                        8'($urandom_range(0, 255)),
                        ($urandom_range(0, 99) < rp), pu, po);
            if (pu) pushed_n = pushed_n + 1;
            cyc = cyc + 1;
        end
        check("random_words_pushed", pushed_n, 10000);
        check("random_drained", sb.size(), 0);

        wr_valid = 1'b0;
        rd_ready = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
